ripple_capture: RTL and testbench
=================================

// Module: ripple_capture
// PURPOSE
//  Downstream consumer of the 4-bit asynchronous ripple counter (outputs q0..q3).
//  - Synchronises the skewed ripple bits into the system clock domain.
//  - Filters settling glitches and extends the 4-bit count to CNT_W bits by counting wraps.
//  - Presents each new value on a valid/ready interface with an overrun flag and a compare match.
// PARAMETERS
//  CNT_W          8   extended count width; minimum 5. Low 4 bits = ripple nibble.
//  STABLE_CYCLES  2   consecutive identical synced samples needed to accept a nibble; minimum 1.
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  q0..q3     in   1 ea   ripple counter bits, asynchronous to clk; q0 = LSB
//  clr        in   1      sync clear of extended count, ovf and step_err; accepted nibble := current synced nibble
//  match_val  in   CNT_W  compare value
//  out_ready  in   1      consumer ready
//  out_valid  out  1      out_count holds an unconsumed update
//  out_count  out  CNT_W  extended count {wraps, nibble}
//  match      out  1      1-cycle pulse when a committed count == match_val
//  ovf        out  1      sticky: an update was overwritten before being consumed
//  step_err   out  1      1-cycle pulse on an illegal step (RIPPLE_STEP_CHECK_EN only)
// BEHAVIOUR
//  Reset (rst=0, async): sync flops, filter, accepted nibble, wrap count, out_count = 0;
//    out_valid, match, ovf, step_err = 0; FSM -> WAIT.
//  Sync: 2-flop synchroniser on {q3,q2,q1,q0}; sn = output of stage 2.
//  Filter FSM; acc = last accepted nibble, cand = candidate nibble, stab = sample counter:
//   - WAIT: sn==acc -> stay. sn!=acc -> cand=sn, stab=1, go SETTLE.
//   - SETTLE: sn!=cand -> if sn==acc go WAIT, else cand=sn, stab=1.
//     sn==cand -> stab+1; when stab reaches STABLE_CYCLES go COMMIT.
//   - COMMIT (one cycle) -> WAIT:
//       acc=cand.
//       If cand<acc_old, wrap count +1, modulo 2^(CNT_W-4). Any decrease counts as a wrap.
//       out_count={wrap,cand}. out_valid=1. match=(new out_count==match_val).
//  Latency: stable pin change -> out_valid high after exactly 2+STABLE_CYCLES+1 rising edges.
//  Handshake:
//   - out_valid && out_ready on an edge -> out_valid clears the next cycle unless a COMMIT occurs in that same cycle.
//   - COMMIT while out_valid && !out_ready -> out_count overwritten, out_valid stays 1, ovf set (sticky).
//   - COMMIT in the same cycle as a handshake -> new data, out_valid stays 1, no ovf.
//   - out_count holds its value while out_valid=0.
//  clr: has priority over COMMIT in the same cycle.
//    - wrap=0, acc=sn, out_count=0, ovf=0, out_valid=0; FSM -> WAIT; no match pulse.
//  Wrap count overflow: silently wraps to 0; no flag.
//  Reset mid-SETTLE discards the candidate; after release, the first stable nonzero nibble commits normally.
// CONFIGURATION
//  RIPPLE_STEP_CHECK_EN defined:
//   - At COMMIT, step_err pulses for 1 cycle if cand != (acc_old+1) mod 16.
//   - Commit still proceeds; the wrap rule is unchanged.
//  RIPPLE_STEP_CHECK_EN undefined: step_err tied to 0; no step logic.
// TESTING (CNT_W=8, STABLE_CYCLES=2)
//  1. rst=0 with q=4'hA held -> all outputs 0. Release -> commit of 8'h0A after 5 edges.
//  2. q 0->1, held 10 cycles, out_ready=1:
//     -> out_valid high 5 edges after the change, out_count=8'h01, single 1-cycle valid.
//  3. Step 0..15 then 0, each held 8 cycles:
//     -> out_count sequence 1..15 then 8'h10. match_val=8'h10 gives one match pulse.
//  4. 0011 -> 0111 for 1 cycle -> 0100 held:
//     -> only 8'h04 committed; no 8'h07 commit. step_err=1 only if macro defined (3->4 is legal; so step_err=0).
//  5. out_ready=0 across two commits (1, then 2):
//     -> out_count=2, ovf=1, out_valid stays 1. clr pulse -> ovf=0, out_valid=0, out_count=0.
//  6. Macro on: 3 -> 5 held -> commit 8'h05 with step_err pulse. Macro off: step_err stays 0.

Source files
------------

// File: rtl/ripple_capture.sv
// ---------------------------------------------------------------------------
// ripple_capture
//
// Consumes the four outputs of an asynchronous 4-bit ripple counter and turns
// them into a clean, extended count in the clk domain.
//   1. A 2-flop synchroniser brings {q3,q2,q1,q0} into the clk domain.
//   2. A small filter FSM accepts a new nibble only after it has been seen
//      STABLE_CYCLES times in a row. This rejects the transient codes a
//      ripple counter shows while its bits settle.
//   3. Every accepted nibble that is lower than the previous one counts as a
//      wrap. The wrap count forms the upper CNT_W-4 bits of the output.
//   4. Each accepted value is offered on a valid/ready output, together with
//      an overrun flag and a compare match pulse.
//
// Build option:
//   RIPPLE_STEP_CHECK_EN  when defined, step_err pulses at a commit whose
//                         nibble is not the previous nibble + 1 (mod 16).
//                         When undefined, step_err is tied to 0.
//
// Parameters:
//   CNT_W          extended count width (>= 5); low 4 bits are the nibble
//   STABLE_CYCLES  consecutive equal synced samples to accept a nibble (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   q0..q3     ripple counter bits (async to clk), q0 = LSB
//   clr        synchronous clear of the wrap count, ovf and output; the
//              accepted nibble becomes the current synced nibble
//   match_val  compare value for match
//   out_ready  consumer ready
//   out_valid  out_count holds an unconsumed update
//   out_count  extended count {wraps, nibble}
//   match      1-cycle pulse when a committed count equals match_val
//   ovf        sticky: an update was overwritten before it was consumed
//   step_err   1-cycle pulse on an illegal step (build option only)
//   fsm_state  filter FSM state for observation (0 WAIT, 1 SETTLE, 2 COMMIT)
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. out_valid then drops unless a new commit lands on the
// same edge. A commit always loads out_count and raises out_valid. If the
// previous value was still pending (out_valid && !out_ready), ovf is set.
// out_count is held while out_valid is 0.
// ---------------------------------------------------------------------------
module ripple_capture #(
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q0,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  input  logic             clr,
  input  logic [CNT_W-1:0] match_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  output logic             match,
  output logic             ovf,
  output logic             step_err,
  output logic [1:0]       fsm_state
);

  localparam int WRAP_W = CNT_W - 4;
  // The sample counter must be able to hold values up to STABLE_CYCLES.
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic [3:0]        sn;
  logic [3:0]        acc;
  logic [3:0]        cand;
  logic [SW-1:0]     stab;
  logic [WRAP_W-1:0] wrap;
  logic [WRAP_W-1:0] wrap_next;
  logic [CNT_W-1:0]  count_next;

  assign fsm_state = state;
  assign sn        = sync2;

  // Two-stage synchroniser. Individual bits may resolve on different cycles.
  // The filter below absorbs the resulting transient codes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {q3, q2, q1, q0};
      sync2 <= sync1;
    end
  end

  // Any decrease of the accepted nibble counts as one wrap. This covers the
  // case where the counter skips past 15 between two samples.
  always_comb begin
    wrap_next  = wrap;
    if (cand < acc) begin
      wrap_next = wrap + 1'b1;
    end
    count_next = {wrap_next, cand};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_WAIT;
      acc       <= '0;
      cand      <= '0;
      stab      <= '0;
      wrap      <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      match     <= 1'b0;
      ovf       <= 1'b0;
`ifdef RIPPLE_STEP_CHECK_EN
      step_err  <= 1'b0;
`endif
    end else begin
      match    <= 1'b0;
`ifdef RIPPLE_STEP_CHECK_EN
      step_err <= 1'b0;
`endif
      if (clr) begin
        // Clear wins over a commit on the same edge. Re-basing acc on the
        // present synced nibble avoids a spurious commit right afterwards.
        state     <= ST_WAIT;
        acc       <= sn;
        cand      <= sn;
        stab      <= '0;
        wrap      <= '0;
        out_count <= '0;
        out_valid <= 1'b0;
        ovf       <= 1'b0;
      end else begin
        case (state)
          ST_WAIT: begin
            if (sn != acc) begin
              cand  <= sn;
              stab  <= SW'(1);
              state <= (STABLE_CYCLES == 1) ? ST_COMMIT : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (sn != cand) begin
              if (sn == acc) begin
                // Glitch back to the accepted value: nothing to report.
                state <= ST_WAIT;
              end else begin
                cand <= sn;
                stab <= SW'(1);
              end
            end else if (stab >= STAB_LAST) begin
              state <= ST_COMMIT;
            end else begin
              stab <= stab + 1'b1;
            end
          end
          ST_COMMIT: begin
            state <= ST_WAIT;
          end
          default: begin
            state <= ST_WAIT;
          end
        endcase

        if (state == ST_COMMIT) begin
          acc       <= cand;
          wrap      <= wrap_next;
          out_count <= count_next;
          out_valid <= 1'b1;
          match     <= (count_next == match_val);
          if (out_valid && !out_ready) begin
            ovf <= 1'b1;
          end
`ifdef RIPPLE_STEP_CHECK_EN
          step_err <= (cand != 4'(acc + 4'd1));
`endif
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifndef RIPPLE_STEP_CHECK_EN
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_capture.sv
// ---------------------------------------------------------------------------
// tb_ripple_capture
//
// Directed bench for ripple_capture with CNT_W=8 and STABLE_CYCLES=2.
// A behavioural model predicts every output on every cycle. The model
// watches the raw pin history and looks for a run of STABLE_CYCLES equal
// synced samples. Hand-computed literal expectations pin both the model and
// the DUT in each directed scenario.
// ---------------------------------------------------------------------------
module tb_ripple_capture;

  localparam int CNT_W  = 8;
  localparam int STABLE = 2;
`ifdef RIPPLE_STEP_CHECK_EN
  localparam int STEP_EN = 1;
`else
  localparam int STEP_EN = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             q0 = 1'b0;
  logic             q1 = 1'b0;
  logic             q2 = 1'b0;
  logic             q3 = 1'b0;
  logic             clr = 1'b0;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] match_val = 8'hFF;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             match;
  logic             ovf;
  logic             step_err;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  ripple_capture #(.CNT_W(CNT_W), .STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .clr       (clr),
    .match_val (match_val),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_count (out_count),
    .match     (match),
    .ovf       (ovf),
    .step_err  (step_err),
    .fsm_state (fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // qh[0] is the pin value sampled at the latest edge. The synced nibble
  // that the DUT acts on at an edge is qh[2].
  logic [3:0]       qh [0:15];
  logic [3:0]       m_acc;
  logic [3:0]       m_wrap;
  logic [CNT_W-1:0] m_count;
  logic             m_valid;
  logic             m_match;
  logic             m_ovf;
  logic             m_step;
  logic [3:0]       mv;
  bit               run_done;
  logic [CNT_W-1:0] exp_q [$];   // model commits, in order
  logic [CNT_W-1:0] dut_log [$]; // DUT values taken by the consumer
  int               match_cnt = 0;
  int               step_cnt  = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) qh[i] = 4'h0;
    m_acc   = 4'h0;
    m_wrap  = 4'h0;
    m_count = '0;
    m_valid = 1'b0;
    m_match = 1'b0;
    m_ovf   = 1'b0;
    m_step  = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 15; i > 0; i--) qh[i] = qh[i-1];
      qh[0]   = {q3, q2, q1, q0};
      m_match = 1'b0;
      m_step  = 1'b0;
      if (clr) begin
        m_acc   = qh[2];
        m_wrap  = 4'h0;
        m_count = '0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
      end else begin
        // A value is committed one edge after its run of synced samples
        // first reaches STABLE in length.
        mv       = qh[3];
        run_done = 1'b1;
        for (int i = 3; i < 3 + STABLE; i++) if (qh[i] != mv) run_done = 1'b0;
        if (qh[3 + STABLE] == mv) run_done = 1'b0;
        if (run_done && mv != m_acc) begin
          if (mv < m_acc) m_wrap = m_wrap + 4'd1;
          if (STEP_EN != 0) m_step = (mv != 4'(m_acc + 4'd1));
          if (m_valid && !out_ready) m_ovf = 1'b1;
          m_acc   = mv;
          m_count = {m_wrap, mv};
          m_valid = 1'b1;
          m_match = (m_count == match_val);
          exp_q.push_back(m_count);
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (!rst) model_reset();
    check("out_valid", out_valid, m_valid);
    check("out_count", out_count, m_count);
    check("match",     match,     m_match);
    check("ovf",       ovf,       m_ovf);
    check("step_err",  step_err,  m_step);
    if (rst && out_valid && out_ready) dut_log.push_back(out_count);
    if (match) match_cnt++;
    if (step_err) step_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_q(input logic [3:0] v);
    {q3, q2, q1, q0} = v;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // Count the negedges until out_valid rises (0 = never within the budget).
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [CNT_W-1:0] log_at(input int i);
    return (i < dut_log.size()) ? dut_log[i] : 8'hEE;
  endfunction

  function automatic logic [CNT_W-1:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 8'hEE;
  endfunction

  // ---------------- stimulus ----------------
  int               lat;
  logic [CNT_W-1:0] t3_exp [16];

  initial begin
    // 1. reset with q=A held; release; commit 0x0A after 5 edges
    set_q(4'hA);
    rst = 1'b0;
    tick(3);
    #2;
    check("t1_rst_valid", out_valid, 1'b0);
    check("t1_rst_count", out_count, 8'h00);
    check("t1_rst_match", match, 1'b0);
    check("t1_rst_ovf", ovf, 1'b0);
    check("t1_rst_step", step_err, 1'b0);
    check("t1_rst_state", fsm_state, 2'd0);
    tick(1);
    rst = 1'b1;
    exp_q.delete();
    dut_log.delete();
    wait_valid(lat);
    check("t1_latency", lat, 5);
    check("t1_count", out_count, 8'h0A);
    check("t1_model", exp_at(0), 8'h0A);

    // 2. 0 -> 1 change, out_ready=1: 5-edge latency, single valid cycle
    tick(1);
    set_q(4'h0);
    tick(8);
    clr_pulse();
    tick(2);
    dut_log.delete();
    exp_q.delete();
    set_q(4'h1);
    wait_valid(lat);
    check("t2_latency", lat, 5);
    check("t2_count", out_count, 8'h01);
    tick(1);
    #2;
    check("t2_valid_drop", out_valid, 1'b0);
    tick(5);
    check("t2_log_size", dut_log.size(), 1);
    check("t2_log0", log_at(0), 8'h01);
    check("t2_model", exp_at(0), 8'h01);

    // 3. count 1..15 then 0: wrap to 0x10, one match on 0x10
    set_q(4'h0);
    tick(8);
    clr_pulse();
    match_val = 8'h10;
    tick(2);
    dut_log.delete();
    exp_q.delete();
    match_cnt = 0;
    for (int i = 0; i < 15; i++) t3_exp[i] = 8'(i + 1);
    t3_exp[15] = 8'h10;
    for (int v = 1; v < 16; v++) begin
      set_q(4'(v));
      tick(8);
    end
    set_q(4'h0);
    tick(8);
    check("t3_log_size", dut_log.size(), 16);
    check("t3_model_size", exp_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_log%0d", i), log_at(i), t3_exp[i]);
      check($sformatf("t3_model%0d", i), exp_at(i), t3_exp[i]);
    end
    check("t3_match_cnt", match_cnt, 1);
    check("t3_count", out_count, 8'h10);
    match_val = 8'hFF;

    // 4. 3 -> 7 (one cycle) -> 4: only 0x14 committed, legal step
    set_q(4'h3);
    tick(8);
    dut_log.delete();
    step_cnt = 0;
    set_q(4'h7);
    tick(1);
    set_q(4'h4);
    tick(8);
    check("t4_log_size", dut_log.size(), 1);
    check("t4_log0", log_at(0), 8'h14);
    check("t4_step_cnt", step_cnt, 0);

    // 5. out_ready=0 across commits 1 then 2: overwrite, ovf; clr recovers
    set_q(4'h0);
    tick(8);
    clr_pulse();
    out_ready = 1'b0;
    set_q(4'h1);
    tick(8);
    set_q(4'h2);
    tick(8);
    #2;
    check("t5_count", out_count, 8'h02);
    check("t5_ovf", ovf, 1'b1);
    check("t5_valid", out_valid, 1'b1);
    tick(1);
    clr_pulse();
    #2;
    check("t5_clr_ovf", ovf, 1'b0);
    check("t5_clr_valid", out_valid, 1'b0);
    check("t5_clr_count", out_count, 8'h00);
    tick(1);
    out_ready = 1'b1;

    // 6. 3 -> 5: commit 0x05; step_err only with the build option
    set_q(4'h3);
    tick(8);
    dut_log.delete();
    step_cnt = 0;
    set_q(4'h5);
    tick(8);
    check("t6_log_size", dut_log.size(), 1);
    check("t6_log0", log_at(0), 8'h05);
    check("t6_step_cnt", step_cnt, STEP_EN);

    // 7. reset while settling on 9; after release 9 commits normally
    set_q(4'h9);
    tick(3);
    rst = 1'b0;
    tick(2);
    #2;
    check("t7_rst_valid", out_valid, 1'b0);
    check("t7_rst_count", out_count, 8'h00);
    check("t7_rst_state", fsm_state, 2'd0);
    tick(1);
    rst = 1'b1;
    wait_valid(lat);
    check("t7_latency", lat, 5);
    check("t7_count", out_count, 8'h09);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
